fetch_step_ctrl: RTL
====================

// Module: fetch_step_ctrl
// PURPOSE
// - Sequencer in front of the processor datapath: walks the 2-bit instruction address through
//   the instruction store at a divided-down rate, captures each 8-bit instruction into result.
// - Sits between the instruction ROM (address out, instruction in) and the display/datapath
//   consuming result; replaces free-running address stepping with an explicit FSM.
// - Supports run/stop, wrap-around at the last address, and a halt opcode.
// PARAMETERS
// - ADDR_W     2           width of instruction address
// - INST_W     8           width of instruction / result
// - LAST_ADDR  3           highest address; next address after it is 0
// - TICK_DIV   50_000_000  clk cycles per step interval (>=2)
// - HALT_OP    8'hFF       instruction value that stops sequencing
// PORTS
// - clk           in   1       system clock, all state on posedge
// - rst           in   1       asynchronous, active-low reset
// - run           in   1       level; 1 = sequence continuously
// - step          in   1       single-step request (used only with SINGLE_STEP_EN)
// - instruction   in   INST_W  ROM data for current address, valid 1 cycle after address changes
// - address       out  ADDR_W  registered instruction address
// - result        out  INST_W  registered last captured instruction
// - result_valid  out  1       1-cycle pulse, result updated this cycle
// - halted        out  1       1 while in HALTED
// - state         out  3       current FSM encoding (debug)
// BEHAVIOUR
// - Reset (rst=0, async): address=0, result=0, result_valid=0, halted=0, state=IDLE, tick_cnt=0.
// - States: IDLE=0, WAIT=1, FETCH=2, CAPTURE=3, HALTED=4; other encodings -> IDLE next cycle.
// - IDLE: run=1 -> WAIT with tick_cnt=0. Else stay.
// - WAIT: tick_cnt increments each cycle; when tick_cnt==TICK_DIV-1 -> FETCH, tick_cnt=0.
//   run=0 in WAIT -> IDLE, tick_cnt=0, address held (resume from same address).
// - FETCH: exactly 1 cycle, address stable, ROM settles -> CAPTURE. run ignored.
// - CAPTURE: exactly 1 cycle; on exit edge result<=instruction, result_valid<=1.
//   instruction==HALT_OP -> HALTED, address NOT advanced.
//   else address<= (address==LAST_ADDR) ? 0 : address+1; -> WAIT if run=1, else IDLE.
// - result_valid cleared on the edge after it is set; never high two consecutive cycles.
// - HALTED: halted=1; run=0 -> IDLE (halted=0), address unchanged; run=1 -> stay.
// - Latency: tick expiry to result_valid = 2 cycles; step interval in run = TICK_DIV+2 cycles.
// - address+1 computed in ADDR_W bits; LAST_ADDR < 2**ADDR_W; wrap checked against LAST_ADDR.
// - Reset mid-instruction (FETCH/CAPTURE): instruction discarded, all outputs to reset values.
// - run toggling in FETCH/CAPTURE: instruction always completes; run sampled at CAPTURE exit.
// CONFIGURATION
// - SINGLE_STEP_EN defined: step rising edge (registered, prior-cycle compare) in IDLE with
//   run=0 -> FETCH directly (no tick wait), CAPTURE then IDLE; step edges in other states ignored.
//   run=1 and step edge same cycle in IDLE: run wins (-> WAIT).
// - SINGLE_STEP_EN undefined: step port present, unused; no step edge register instantiated.
// TESTING (TICK_DIV=4, ROM {0:8'h11,1:8'h22,2:8'h33,3:8'h44})
// - Reset released, run=0 for 20 cycles -> address=0, result=0, result_valid never 1, state=IDLE.
// - run=1 held -> result_valid pulses every 6 cycles; result 11,22,33,44,11; address wraps 3->0.
// - run dropped during WAIT after capturing 22 -> IDLE, address=2; run=1 again -> next result=33.
// - ROM[2]=8'hFF, run=1 -> result=FF, halted=1, address stays 2; run=0 -> IDLE, halted=0.
// - rst pulsed low during CAPTURE -> immediately address=0, result=0, result_valid=0, state=IDLE.
// - SINGLE_STEP_EN, run=0, three step pulses -> result 11,22,33, each result_valid 2 cycles
//   after step edge; without macro same stimulus -> no result_valid, address=0.

Source files
------------

// File: rtl/fetch_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_step_ctrl
// Description : Walks the instruction address through the instruction store
//               at a divided-down rate and captures each instruction into
//               result. The optional single-step mode is enabled by defining
//               SINGLE_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_step_ctrl #(
    parameter int                ADDR_W    = 2,
    parameter int                INST_W    = 8,
    parameter int                LAST_ADDR = 3,
    parameter int                TICK_DIV  = 50_000_000,
    parameter logic [INST_W-1:0] HALT_OP   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic [INST_W-1:0] instruction,
    output logic [ADDR_W-1:0] address,
    output logic [INST_W-1:0] result,
    output logic              result_valid,
    output logic              halted,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_FETCH   = 3'd2,
        S_CAPTURE = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    localparam int                 c_TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0]   c_LAST_ADDR = ADDR_W'(LAST_ADDR);

    state_t              r_state;
    logic [c_TICK_W-1:0] r_tick;
    logic [ADDR_W-1:0]   r_address;
    logic [INST_W-1:0]   r_result;
    logic                r_result_valid;
    logic                r_halted;

    logic                w_step_edge;
    logic [ADDR_W-1:0]   w_next_addr;

`ifdef SINGLE_STEP_EN
    logic r_step_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step;
        end
    end

    assign w_step_edge = step & ~r_step_q;
`else
    logic w_unused_step;

    assign w_unused_step = step;
    assign w_step_edge   = 1'b0;
`endif

    // Wrap is checked against LAST_ADDR, not the natural ADDR_W rollover.
    assign w_next_addr = (r_address == c_LAST_ADDR) ? '0 : r_address + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_tick         <= '0;
            r_address      <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_halted       <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tick <= '0;
                    if (run) begin
                        r_state <= S_WAIT;
                    end else if (w_step_edge) begin
                        r_state <= S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                        r_tick  <= '0;
                    end else if (r_tick == c_TICK_LAST) begin
                        r_state <= S_FETCH;
                        r_tick  <= '0;
                    end else begin
                        r_tick <= r_tick + c_TICK_W'(1);
                    end
                end
                S_FETCH: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_result       <= instruction;
                    r_result_valid <= 1'b1;
                    // A halt opcode leaves the address on the halting instruction.
                    if (instruction == HALT_OP) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_address <= w_next_addr;
                        r_state   <= run ? S_WAIT : S_IDLE;
                    end
                end
                S_HALTED: begin
                    if (!run) begin
                        r_state  <= S_IDLE;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_tick   <= '0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign address      = r_address;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign halted       = r_halted;
    assign state        = r_state;

endmodule
`default_nettype wire
